// File: rtl/xgmii_pkg.sv
// Shared constants, enums and block-classification helpers for the 64b/66b
// receive decoder.
package xgmii_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam logic [7:0] BT_C8   = 8'h1E;
    localparam logic [7:0] BT_C4_O = 8'h4B;
    localparam logic [7:0] BT_S0   = 8'h78;
    localparam logic [7:0] BT_C_S4 = 8'h33;
    localparam logic [7:0] BT_T0   = 8'h87;
    localparam logic [7:0] BT_T1   = 8'h99;
    localparam logic [7:0] BT_T2   = 8'hAA;
    localparam logic [7:0] BT_T3   = 8'hB4;
    localparam logic [7:0] BT_T4   = 8'hCC;
    localparam logic [7:0] BT_T5   = 8'hD2;
    localparam logic [7:0] BT_T6   = 8'hE1;
    localparam logic [7:0] BT_T7   = 8'hFF;

    localparam logic [7:0] XG_IDLE  = 8'h07;
    localparam logic [7:0] XG_START = 8'hFB;
    localparam logic [7:0] XG_TERM  = 8'hFD;
    localparam logic [7:0] XG_ERROR = 8'hFE;
    localparam logic [7:0] XG_SEQ   = 8'h9C;

    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    localparam logic [3:0] TERM_NONE = 4'd8;

    typedef enum logic [2:0] {
        BLK_C = 3'd0,
        BLK_S = 3'd1,
        BLK_T = 3'd2,
        BLK_D = 3'd3,
        BLK_E = 3'd4
    } blk_class_e;

    typedef enum logic [2:0] {
        RX_INIT = 3'd0,
        RX_C    = 3'd1,
        RX_D    = 3'd2,
        RX_T    = 3'd3,
        RX_E    = 3'd4
    } rx_state_e;

    function automatic logic [7:0] code_ok_mask(input logic [63:0] tdata);
        logic [6:0] code;
        code_ok_mask = 8'h00;
        for (int m = 0; m < 8; m++) begin
            code = tdata[8+7*m +: 7];
            code_ok_mask[m] = (code == CODE_IDLE) || (code == CODE_ERROR);
        end
    endfunction

    function automatic logic [7:0] code_char(input logic [6:0] code);
        code_char = (code == CODE_ERROR) ? XG_ERROR : XG_IDLE;
    endfunction

    // Lane index of the terminate character, TERM_NONE for non-terminate types.
    function automatic logic [3:0] term_pos(input logic [7:0] btype);
        case (btype)
            BT_T0:   term_pos = 4'd0;
            BT_T1:   term_pos = 4'd1;
            BT_T2:   term_pos = 4'd2;
            BT_T3:   term_pos = 4'd3;
            BT_T4:   term_pos = 4'd4;
            BT_T5:   term_pos = 4'd5;
            BT_T6:   term_pos = 4'd6;
            BT_T7:   term_pos = 4'd7;
            default: term_pos = TERM_NONE;
        endcase
    endfunction

    function automatic blk_class_e classify(input logic [1:0] ttype, input logic [63:0] tdata);
        logic [7:0] ok;
        logic [3:0] k;
        logic [6:0] sh;
        ok = code_ok_mask(tdata);
        k  = term_pos(tdata[7:0]);
        sh = 7'd8 + {1'b0, k[2:0], 3'b000};
        classify = BLK_E;
        if (ttype == SH_DATA) begin
            classify = BLK_D;
        end else if (ttype == SH_CTRL) begin
            if (tdata[7:0] == BT_C8 && (&ok)) begin
                classify = BLK_C;
            end else if (tdata[7:0] == BT_C4_O && tdata[35:32] == 4'h0 && (&ok[7:4])) begin
                classify = BLK_C;
            end else if (tdata[7:0] == BT_S0) begin
                classify = BLK_S;
            end else if (tdata[7:0] == BT_C_S4 && (&ok[3:0])) begin
                classify = BLK_S;
            end else if (k != TERM_NONE && (tdata >> sh) == 64'd0) begin
                classify = BLK_T;
            end else begin
                classify = BLK_E;
            end
        end else begin
            classify = BLK_E;
        end
    endfunction

endpackage

// File: rtl/xgmii_block_decode.sv
// Combinational classify and XGMII decode of the held block, plus the class
// of its successor for the terminate lookahead.
module xgmii_block_decode
    import xgmii_pkg::*;
(
    input  logic [1:0]  i_ttype,
    input  logic [63:0] i_tdata,
    input  logic [1:0]  i_next_ttype,
    input  logic [63:0] i_next_tdata,
    output blk_class_e  o_class,
    output blk_class_e  o_next_class,
    output logic [63:0] o_data,
    output logic [7:0]  o_ctrl
);

    logic [63:0] w_chars;
    logic [63:0] w_payload;
    logic [3:0]  w_k;

    assign o_class      = classify(i_ttype, i_tdata);
    assign o_next_class = classify(i_next_ttype, i_next_tdata);
    assign w_payload    = {8'h00, i_tdata[63:8]};
    assign w_k          = term_pos(i_tdata[7:0]);

    // Translate the eight 7-bit control codes into XGMII characters.
    always_comb begin
        w_chars = 64'd0;
        for (int m = 0; m < 8; m++) begin
            w_chars[8*m +: 8] = code_char(i_tdata[8+7*m +: 7]);
        end
    end

    // Lane assembly per block class; unknown blocks fall back to the error pattern.
    always_comb begin
        o_data = {8{XG_ERROR}};
        o_ctrl = 8'hFF;
        case (o_class)
            BLK_D: begin
                o_data = i_tdata;
                o_ctrl = 8'h00;
            end
            BLK_C: begin
                if (i_tdata[7:0] == BT_C8) begin
                    o_data = w_chars;
                    o_ctrl = 8'hFF;
                end else begin
                    o_data = {w_chars[63:32], i_tdata[31:8], XG_SEQ};
                    o_ctrl = 8'hF1;
                end
            end
            BLK_S: begin
                if (i_tdata[7:0] == BT_S0) begin
                    o_data = {i_tdata[63:8], XG_START};
                    o_ctrl = 8'h01;
                end else begin
                    o_data = {i_tdata[63:40], XG_START, w_chars[31:0]};
                    o_ctrl = 8'h1F;
                end
            end
            BLK_T: begin
                for (int j = 0; j < 8; j++) begin
                    if (j < int'(w_k)) begin
                        o_data[8*j +: 8] = w_payload[8*j +: 8];
                        o_ctrl[j]        = 1'b0;
                    end else if (j == int'(w_k)) begin
                        o_data[8*j +: 8] = XG_TERM;
                        o_ctrl[j]        = 1'b1;
                    end else begin
                        o_data[8*j +: 8] = XG_IDLE;
                        o_ctrl[j]        = 1'b1;
                    end
                end
            end
            default: begin
                o_data = {8{XG_ERROR}};
                o_ctrl = 8'hFF;
            end
        endcase
    end

endmodule

// File: rtl/xgmii_rx_decoder.sv
// 64b/66b receive decoder: holds one block for lookahead, runs the receive
// state machine and emits decoded or error XGMII words on an AXI-Stream port.
module xgmii_rx_decoder
    import xgmii_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           s_axis_ttype,
    input  logic [63:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [63:0]          m_axis_tdata,
    output logic [7:0]           m_axis_tctrl,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    rx_state_e             r_state;
    rx_state_e             w_trans;
    rx_state_e             w_next_state;
    logic                  r_h_valid;
    logic [1:0]            r_h_ttype;
    logic [63:0]           r_h_tdata;
    logic [63:0]           r_m_tdata;
    logic [7:0]            r_m_tctrl;
    logic                  r_m_tvalid;
    logic [ERR_CNT_W-1:0]  r_err_count;
    logic                  w_accept;
    logic                  w_emit;
    logic                  w_is_err;
    logic                  w_term_ok;
    blk_class_e            w_h_class;
    blk_class_e            w_next_class;
    logic [63:0]           w_dec_data;
    logic [7:0]            w_dec_ctrl;

    xgmii_block_decode u_decode (
        .i_ttype      (r_h_ttype),
        .i_tdata      (r_h_tdata),
        .i_next_ttype (s_axis_ttype),
        .i_next_tdata (s_axis_tdata),
        .o_class      (w_h_class),
        .o_next_class (w_next_class),
        .o_data       (w_dec_data),
        .o_ctrl       (w_dec_ctrl)
    );

    assign s_axis_tready = !r_m_tvalid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_emit        = w_accept && r_h_valid;
    assign w_term_ok     = (w_h_class == BLK_T) &&
                           (w_next_class == BLK_C || w_next_class == BLK_S);
    assign w_is_err      = (w_trans == RX_E);
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tctrl  = r_m_tctrl;
    assign m_axis_tvalid = r_m_tvalid;
    assign err_count     = r_err_count;

    // Transition taken by the held block; applied only when it is emitted.
    always_comb begin
        w_trans = RX_E;
        case (r_state)
            RX_INIT, RX_C, RX_T: begin
                if (w_h_class == BLK_C)      w_trans = RX_C;
                else if (w_h_class == BLK_S) w_trans = RX_D;
                else                         w_trans = RX_E;
            end
            RX_D: begin
                if (w_h_class == BLK_D) w_trans = RX_D;
                else if (w_term_ok)     w_trans = RX_T;
                else                    w_trans = RX_E;
            end
            RX_E: begin
                if (w_h_class == BLK_C)      w_trans = RX_C;
                else if (w_h_class == BLK_D) w_trans = RX_D;
                else if (w_term_ok)          w_trans = RX_T;
                else                         w_trans = RX_E;
            end
            default: w_trans = RX_E;
        endcase
        if (w_emit) w_next_state = w_trans;
        else        w_next_state = r_state;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= RX_INIT;
        else          r_state <= w_next_state;
    end

    // Lookahead holding register, output register and saturating error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_valid   <= 1'b0;
            r_h_ttype   <= 2'b00;
            r_h_tdata   <= 64'd0;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= 64'd0;
            r_m_tctrl   <= 8'h00;
            r_err_count <= {ERR_CNT_W{1'b0}};
        end else begin
            if (w_accept) begin
                r_h_valid  <= 1'b1;
                r_h_ttype  <= s_axis_ttype;
                r_h_tdata  <= s_axis_tdata;
                r_m_tvalid <= r_h_valid;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
            if (w_emit) begin
                r_m_tdata <= w_is_err ? {8{XG_ERROR}} : w_dec_data;
                r_m_tctrl <= w_is_err ? 8'hFF : w_dec_ctrl;
                if (w_is_err && r_err_count != ERR_MAX) begin
                    r_err_count <= r_err_count + ERR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_xgmii_rx_decoder.sv
// Directed self-checking bench for xgmii_rx_decoder.
module tb_xgmii_rx_decoder;

    localparam logic [63:0] IDLE_BLK = 64'h0000_0000_0000_001E;
    localparam logic [63:0] IDLE_OUT = 64'h0707_0707_0707_0707;
    localparam logic [63:0] ERR_OUT  = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [63:0] S_BLK    = 64'h7766_5544_3322_1178;
    localparam logic [63:0] S_OUT    = 64'h7766_5544_3322_11FB;
    localparam logic [63:0] T3_BLK   = 64'h0000_0000_AABB_CCB4;
    localparam logic [63:0] T3_OUT   = 64'h0707_0707_FDAA_BBCC;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  s_ttype = 2'b00;
    logic [63:0] s_tdata = 64'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tctrl;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [15:0] err_count;
    int          checks = 0;
    int          failures = 0;
    logic [71:0] got_q[$];

    always #5 clk = ~clk;

    xgmii_rx_decoder #(.ERR_CNT_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axis_ttype  (s_ttype),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tctrl  (m_tctrl),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .err_count     (err_count)
    );

    always @(posedge clk) begin
        if (m_tvalid && m_tready) got_q.push_back({m_tctrl, m_tdata});
    end

    task automatic do_reset();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] tt, input logic [63:0] d);
        bit done = 1'b0;
        s_ttype  = tt;
        s_tdata  = d;
        s_tvalid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        s_tvalid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_timeout: block %h not accepted within 20 cycles", d);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
        if (m_tdata !== 64'd0) begin failures++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
        if (m_tctrl !== 8'h00) begin failures++; $display("FAIL reset_tctrl: got %h want 00", m_tctrl); end
        if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err: got %h want 0", err_count); end
        if (s_tready !== 1'b1) begin failures++; $display("FAIL reset_tready: got %b want 1", s_tready); end
    endtask

    task automatic test_idle_data();
        do_reset();
        send(2'b10, IDLE_BLK);
        checks++;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL first_load_tvalid: got %b want 0", m_tvalid); end
        send(2'b01, 64'h0706_0504_0302_0100);
        checks += 3;
        if (m_tvalid !== 1'b1) begin failures++; $display("FAIL idle_tvalid: got %b want 1", m_tvalid); end
        if (m_tdata !== IDLE_OUT) begin failures++; $display("FAIL idle_tdata: got %h want %h", m_tdata, IDLE_OUT); end
        if (m_tctrl !== 8'hFF) begin failures++; $display("FAIL idle_tctrl: got %h want FF", m_tctrl); end
    endtask

    task automatic test_ordered_set();
        do_reset();
        send(2'b10, 64'h0000_0000_AABB_CC4B);
        send(2'b10, IDLE_BLK);
        checks += 3;
        if (m_tdata !== 64'h0707_0707_AABB_CC9C) begin failures++; $display("FAIL oset_tdata: got %h want 07070707AABBCC9C", m_tdata); end
        if (m_tctrl !== 8'hF1) begin failures++; $display("FAIL oset_tctrl: got %h want F1", m_tctrl); end
        if (err_count !== 16'd0) begin failures++; $display("FAIL oset_err: got %h want 0", err_count); end
    endtask

    task automatic test_start_term();
        do_reset();
        send(2'b10, IDLE_BLK);
        send(2'b10, S_BLK);
        send(2'b01, 64'h0102_0304_0506_0708);
        checks += 2;
        if (m_tdata !== S_OUT) begin failures++; $display("FAIL start_tdata: got %h want %h", m_tdata, S_OUT); end
        if (m_tctrl !== 8'h01) begin failures++; $display("FAIL start_tctrl: got %h want 01", m_tctrl); end
        send(2'b10, T3_BLK);
        checks += 2;
        if (m_tdata !== 64'h0102_0304_0506_0708) begin failures++; $display("FAIL data_tdata: got %h want 0102030405060708", m_tdata); end
        if (m_tctrl !== 8'h00) begin failures++; $display("FAIL data_tctrl: got %h want 00", m_tctrl); end
        send(2'b10, IDLE_BLK);
        checks += 3;
        if (m_tdata !== T3_OUT) begin failures++; $display("FAIL term_tdata: got %h want %h", m_tdata, T3_OUT); end
        if (m_tctrl !== 8'hF8) begin failures++; $display("FAIL term_tctrl: got %h want F8", m_tctrl); end
        if (err_count !== 16'd0) begin failures++; $display("FAIL term_err: got %h want 0", err_count); end
    endtask

    task automatic test_term_error();
        do_reset();
        send(2'b10, IDLE_BLK);
        send(2'b10, S_BLK);
        send(2'b10, T3_BLK);
        send(2'b01, 64'h1111_2222_3333_4444);
        checks += 3;
        if (m_tdata !== ERR_OUT) begin failures++; $display("FAIL term_err_tdata: got %h want %h", m_tdata, ERR_OUT); end
        if (m_tctrl !== 8'hFF) begin failures++; $display("FAIL term_err_tctrl: got %h want FF", m_tctrl); end
        if (err_count !== 16'd1) begin failures++; $display("FAIL term_err_count: got %0d want 1", err_count); end
    endtask

    task automatic test_illegal_header();
        do_reset();
        send(2'b10, IDLE_BLK);
        send(2'b10, IDLE_BLK);
        send(2'b00, 64'h1234_5678_9ABC_DEF0);
        send(2'b10, IDLE_BLK);
        checks += 3;
        if (m_tdata !== ERR_OUT) begin failures++; $display("FAIL illegal_tdata: got %h want %h", m_tdata, ERR_OUT); end
        if (m_tctrl !== 8'hFF) begin failures++; $display("FAIL illegal_tctrl: got %h want FF", m_tctrl); end
        if (err_count !== 16'd1) begin failures++; $display("FAIL illegal_err: got %0d want 1", err_count); end
        send(2'b01, 64'h0F0E_0D0C_0B0A_0908);
        checks += 2;
        if (m_tdata !== IDLE_OUT) begin failures++; $display("FAIL recover_tdata: got %h want %h", m_tdata, IDLE_OUT); end
        if (err_count !== 16'd1) begin failures++; $display("FAIL recover_err: got %0d want 1", err_count); end
        // Data straight after idle is illegal only if the idle really moved the FSM to RX_C.
        send(2'b10, IDLE_BLK);
        checks += 2;
        if (m_tdata !== ERR_OUT) begin failures++; $display("FAIL in_rxc_tdata: got %h want %h", m_tdata, ERR_OUT); end
        if (err_count !== 16'd2) begin failures++; $display("FAIL in_rxc_err: got %0d want 2", err_count); end
    endtask

    task automatic test_backpressure();
        logic [71:0] exp_q[$];
        do_reset();
        got_q.delete();
        send(2'b10, IDLE_BLK);
        send(2'b10, S_BLK);
        send(2'b01, 64'hD1D1_D1D1_D1D1_D1D1);
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks += 3;
            if (s_tready !== 1'b0) begin failures++; $display("FAIL stall_tready c%0d: got %b want 0", c, s_tready); end
            if (m_tvalid !== 1'b1) begin failures++; $display("FAIL stall_tvalid c%0d: got %b want 1", c, m_tvalid); end
            if (m_tdata !== S_OUT) begin failures++; $display("FAIL stall_tdata c%0d: got %h want %h", c, m_tdata, S_OUT); end
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        send(2'b01, 64'hD2D2_D2D2_D2D2_D2D2);
        send(2'b10, IDLE_BLK);
        repeat (3) @(posedge clk);
        #1;
        exp_q = '{{8'hFF, IDLE_OUT}, {8'h01, S_OUT},
                  {8'h00, 64'hD1D1_D1D1_D1D1_D1D1}, {8'h00, 64'hD2D2_D2D2_D2D2_D2D2}};
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_saturate_reset();
        do_reset();
        force dut.r_err_count = 16'hFFFD;
        #1;
        release dut.r_err_count;
        send(2'b11, 64'h1);
        send(2'b11, 64'h2);
        checks += 2;
        if (err_count !== 16'hFFFE) begin failures++; $display("FAIL sat1: got %h want FFFE", err_count); end
        if (m_tdata !== ERR_OUT) begin failures++; $display("FAIL sat1_tdata: got %h want %h", m_tdata, ERR_OUT); end
        send(2'b11, 64'h3);
        checks++;
        if (err_count !== 16'hFFFF) begin failures++; $display("FAIL sat2: got %h want FFFF", err_count); end
        send(2'b00, 64'h4);
        checks++;
        if (err_count !== 16'hFFFF) begin failures++; $display("FAIL sat3: got %h want FFFF", err_count); end
        #2;
        reset_n = 1'b0;
        #1;
        checks += 5;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL async_tvalid: got %b want 0", m_tvalid); end
        if (m_tdata !== 64'd0) begin failures++; $display("FAIL async_tdata: got %h want 0", m_tdata); end
        if (m_tctrl !== 8'h00) begin failures++; $display("FAIL async_tctrl: got %h want 00", m_tctrl); end
        if (err_count !== 16'd0) begin failures++; $display("FAIL async_err: got %h want 0", err_count); end
        if (s_tready !== 1'b1) begin failures++; $display("FAIL async_tready: got %b want 1", s_tready); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(2'b10, IDLE_BLK);
        checks++;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL post_reset_tvalid: got %b want 0", m_tvalid); end
        send(2'b10, IDLE_BLK);
        checks += 2;
        if (m_tdata !== IDLE_OUT) begin failures++; $display("FAIL post_reset_tdata: got %h want %h", m_tdata, IDLE_OUT); end
        if (err_count !== 16'd0) begin failures++; $display("FAIL post_reset_err: got %h want 0", err_count); end
    endtask

    initial begin
        test_reset();
        test_idle_data();
        test_ordered_set();
        test_start_term();
        test_term_error();
        test_illegal_header();
        test_backpressure();
        test_saturate_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
